// File: rtl/param_scan_decoder_pkg.sv
// param_scan_decoder_pkg: shared FSM state type and one-hot decode helper
package param_scan_decoder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_t;
  localparam int MAX_N = 256;
  function automatic logic [MAX_N-1:0] onehot(input logic [7:0] i, input int n);
    return (32'(i) < n) ? MAX_N'(1) << i : '0;
  endfunction
endpackage

// File: rtl/param_scan_decoder_tick_prescaler.sv
// param_scan_decoder_tick_prescaler: dwell counter, ticks once cnt reaches div
module param_scan_decoder_tick_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  // >= so that lowering div below the running count advances at once
  assign tick = cnt_en && (cnt >= div);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (cnt_en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/param_scan_decoder.sv
// param_scan_decoder: registered N-to-2^N decoder with DIRECT and auto-SCAN modes
module param_scan_decoder
  import param_scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DIV_W-1:0]    div,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                wrap
);
  localparam int N = 2**SEL_W;
  localparam logic [N-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;
  state_t state, ns;
  logic tick, adv, clr, cnt_en;
  logic [SEL_W-1:0] idx_n;
  always_comb begin
    ns = !en ? IDLE : (mode ? SCAN : DIRECT);
    // entry into SCAN restarts the dwell; IDLE leaves the count untouched
    clr = (ns == DIRECT) || (ns == SCAN && state != SCAN);
    cnt_en = (ns == SCAN) && (state == SCAN);
    adv = cnt_en && tick;
    idx_n = (ns == DIRECT) ? sel : (adv ? idx + 1'b1 : idx);
  end
  param_scan_decoder_tick_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cnt_en(cnt_en), .div(div), .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      wrap <= 1'b0;
      out <= INACT;
    end else begin
      state <= ns;
      idx <= idx_n;
      wrap <= adv && (idx == '1);
      out <= (ns == IDLE) ? INACT : N'(onehot(8'(idx_n), N)) ^ INACT;
    end
  end
endmodule
